// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing the single FIFO write port among
// N producers. A requester that has just been granted keeps the port while it
// keeps requesting, for up to MAX_BURST consecutive words. After that the scan
// moves on to the other requesters. The grant is combinational, so the word is
// written on the same clock edge that grants it. A full FIFO freezes the
// arbitration state, so a burst resumes where it stopped once the stall clears.
module fifo_wr_arb #(
  parameter int N         = 4,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N-1:0]                     req,
  input  logic [N*DW-1:0]                  din,
  output logic [N-1:0]                     gnt,
  input  logic                             fifo_full,
  output logic                             fifo_we,
  output logic [DW-1:0]                    fifo_din,
  output logic [$clog2(MAX_BURST+1)-1:0]   burst_cnt
);

  localparam int IW = $clog2(N);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_BURST_C = BW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX_C  = IW'(N - 1);

  logic [IW-1:0] last_owner_r;
  logic [BW-1:0] burst_cnt_r;
  logic          locked_r;

  logic          grant_vld_s;
  logic [IW-1:0] grant_idx_s;
  logic          lock_hit_s;
  logic [N-1:0]  gnt_s;
  logic [DW-1:0] din_sel_s;

  // Index reached by stepping 'off' places past 'base', wrapping modulo N.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) begin
      sum = sum - N;
    end else begin
      sum = sum;
    end
    return IW'(sum);
  endfunction

  // Pick the winner: stall on full, else extend the current burst, else round-robin scan.
  always_comb begin
    logic [IW-1:0] cand_v;
    logic          take_v;
    grant_vld_s = 1'b0;
    grant_idx_s = {IW{1'b0}};
    lock_hit_s  = 1'b0;
    cand_v      = {IW{1'b0}};
    take_v      = 1'b0;
    if (fifo_full) begin
      grant_vld_s = 1'b0;
    end else if (locked_r && req[last_owner_r] && (burst_cnt_r < MAX_BURST_C)) begin
      grant_vld_s = 1'b1;
      grant_idx_s = last_owner_r;
      lock_hit_s  = 1'b1;
    end else begin
      // The previous owner is visited last, so it only wins again when nobody else asks.
      for (int o = 1; o <= N; o++) begin
        cand_v      = rr_idx(last_owner_r, o);
        take_v      = !grant_vld_s && req[cand_v];
        grant_idx_s = take_v ? cand_v : grant_idx_s;
        grant_vld_s = grant_vld_s | take_v;
      end
    end
  end

  // Decode the winner into a one-hot grant and steer its data slice to the FIFO.
  always_comb begin
    gnt_s     = {N{1'b0}};
    din_sel_s = {DW{1'b0}};
    for (int i = 0; i < N; i++) begin
      gnt_s[i]  = grant_vld_s && (grant_idx_s == IW'(i));
      din_sel_s = din_sel_s | (din[i*DW +: DW] & {DW{gnt_s[i]}});
    end
  end

  // Qualify with rst_n so an in-flight grant is withdrawn as soon as reset asserts.
  assign gnt       = gnt_s & {N{rst_n}};
  assign fifo_we   = |gnt;
  assign fifo_din  = din_sel_s & {DW{rst_n}};
  assign burst_cnt = burst_cnt_r;

  // Track the owner, its burst length and its lock; freeze everything during a full stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_r <= LAST_IDX_C;
      burst_cnt_r  <= {BW{1'b0}};
      locked_r     <= 1'b0;
    end else if (grant_vld_s) begin
      locked_r <= 1'b1;
      if (lock_hit_s) begin
        // lock_hit_s already implies burst_cnt_r < MAX_BURST, so this saturates.
        burst_cnt_r <= burst_cnt_r + BW'(1'b1);
      end else begin
        last_owner_r <= grant_idx_s;
        burst_cnt_r  <= BW'(1'b1);
      end
    end else if (fifo_full) begin
      last_owner_r <= last_owner_r;
      burst_cnt_r  <= burst_cnt_r;
      locked_r     <= locked_r;
    end else begin
      // Idle cycle: the burst ends, but the round-robin position is kept.
      locked_r    <= 1'b0;
      burst_cnt_r <= {BW{1'b0}};
    end
  end

endmodule
